deteccion_riesgos: RTL and testbench

- Hazard-detection and interlock unit for the filter processor pipeline (IF, ID, EX, MEM, WB).
- Handles the hazards that operand forwarding cannot resolve:
  - load-use: stalls the PC and the IF/ID register, and injects bubbles into ID/EX for the memory read latency;
  - taken branch resolved in EX: flushes the wrong-path instructions.
- Sits beside the ID stage. Its outputs drive the PC enable and the IF/ID and ID/EX pipeline-register controls.

---
 rtl/riesgos_pkg.sv | 15 +
 rtl/contador_stall.sv | 29 ++
 rtl/deteccion_riesgos.sv | 132 +++++++++++++
 tb/tb_deteccion_riesgos.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riesgos_pkg.sv
// Shared types and constants for the hazard-detection unit of the filter pipeline.
package riesgos_pkg;

  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned CNT_W     = 4;

  // Instruction word loaded into IF/ID or ID/EX when flushing or bubbling.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    STALL
  } estado_e;

endpackage

// File: rtl/contador_stall.sv
// Loadable down-counter with zero flag; tracks the remaining load-use stall cycles.
module contador_stall
  import riesgos_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/deteccion_riesgos.sv
// Load-use interlock and taken-branch flush control beside the ID stage.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module deteccion_riesgos
  import riesgos_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Ra_Dec,
  input  logic             RE_A_Dec,
  input  logic [REG_W-1:0] Rb_Dec,
  input  logic             RE_B_Dec,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             WE_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);

  // The first stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1.
  localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  estado_e          state_q, state_d;
  logic             lu;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  assign lu = mem_RE_Reg_Exe & WE_Reg_Exe &
              ((RE_A_Dec & (Ra_Dec == Robj_Reg_Exe)) | (RE_B_Dec & (Rb_Dec == Robj_Reg_Exe)));

  contador_stall u_contador_stall (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d       = state_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    busy          = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
        if (branch_taken_Exe) begin
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (lu) begin
          stall_pc      = 1'b1;
          stall_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_load = 1'b1;
            state_d  = STALL;
          end
        end
      end
      STALL: begin
        stall_pc      = 1'b1;
        stall_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
        busy          = 1'b1;
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
    if (!rst_n) begin
      state_d       = IDLE;
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      bubble_id_exe = 1'b0;
      flush_if_id   = 1'b0;
      busy          = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_pc && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (flush_if_id && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

  // EX holds a bubble during STALL, so a taken branch there means upstream broke protocol.
  a_no_branch_in_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == STALL) |-> !branch_taken_Exe);

  a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == STALL) |-> (cnt <= CNT_INIT));

endmodule

// File: tb/tb_deteccion_riesgos.sv
// Randomized and directed bench for deteccion_riesgos at LOAD_LAT = 1, 2 and 4.
module tb_deteccion_riesgos;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ra, rb, robj;
  logic       re_a, re_b, we, mem_re, br;
  // Per DUT: {stall_pc, stall_if_id, bubble_id_exe, flush_if_id, busy}
  logic [4:0] v1, v2, v4;

  int n_cmp  = 0;
  int n_fail = 0;
  int rem[3];
  int lat[3] = '{1, 2, 4};
  int sc[3];
  int fc[3];

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, sc2, sc4, fc1, fc2, fc4;
`endif

  deteccion_riesgos #(.REG_W(4), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Ra_Dec(ra), .RE_A_Dec(re_a), .Rb_Dec(rb), .RE_B_Dec(re_b),
    .Robj_Reg_Exe(robj), .WE_Reg_Exe(we), .mem_RE_Reg_Exe(mem_re), .branch_taken_Exe(br),
    .stall_pc(v1[4]), .stall_if_id(v1[3]), .bubble_id_exe(v1[2]), .flush_if_id(v1[1]),
    .busy(v1[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  deteccion_riesgos #(.REG_W(4), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Ra_Dec(ra), .RE_A_Dec(re_a), .Rb_Dec(rb), .RE_B_Dec(re_b),
    .Robj_Reg_Exe(robj), .WE_Reg_Exe(we), .mem_RE_Reg_Exe(mem_re), .branch_taken_Exe(br),
    .stall_pc(v2[4]), .stall_if_id(v2[3]), .bubble_id_exe(v2[2]), .flush_if_id(v2[1]),
    .busy(v2[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc2), .flush_count(fc2)
`endif
  );

  deteccion_riesgos #(.REG_W(4), .LOAD_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Ra_Dec(ra), .RE_A_Dec(re_a), .Rb_Dec(rb), .RE_B_Dec(re_b),
    .Robj_Reg_Exe(robj), .WE_Reg_Exe(we), .mem_RE_Reg_Exe(mem_re), .branch_taken_Exe(br),
    .stall_pc(v4[4]), .stall_if_id(v4[3]), .bubble_id_exe(v4[2]), .flush_if_id(v4[1]),
    .busy(v4[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc4), .flush_count(fc4)
`endif
  );

  // Reference: a unit is either idle or has 'rem' stall cycles still owed.
  function automatic logic model_lu();
    return mem_re && we && ((re_a && (ra == robj)) || (re_b && (rb == robj)));
  endfunction

  function automatic logic [4:0] model_out(input int r);
    if (!rst_n) return 5'b00000;
    if (r > 0) return 5'b11101;
    if (br) return 5'b00110;
    if (model_lu()) return 5'b11100;
    return 5'b00000;
  endfunction

  function automatic logic [14:0] model_all();
    return {model_out(rem[2]), model_out(rem[1]), model_out(rem[0])};
  endfunction

  task automatic model_step();
    logic [4:0] o;
    for (int i = 0; i < 3; i++) begin
      o = model_out(rem[i]);
      if (!rst_n) begin
        sc[i] = 0;
        fc[i] = 0;
      end else begin
        if (o[4] && sc[i] < 65535) sc[i]++;
        if (o[1] && fc[i] < 65535) fc[i]++;
      end
      if (!rst_n) rem[i] = 0;
      else if (rem[i] > 0) rem[i]--;
      else if (!br && model_lu()) rem[i] = lat[i] - 1;
    end
  endtask

  task automatic drive(input logic r, input int a, input logic ea, input int b, input logic eb,
                       input int o, input logic w, input logic m, input logic bt);
    rst_n = r; ra = 4'(a); re_a = ea; rb = 4'(b); re_b = eb;
    robj = 4'(o); we = w; mem_re = m; br = bt;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3, 1'b1, 3, 1'b1, 3, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      obs = {v4, v2, v1};
      n_cmp++;
      if (obs !== 15'b0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b want=%b", k, obs, 15'b0);
      end
      advance();
    end
  endtask

  // One load-use hazard then EX bubbles; counts stall cycles per unit.
  task automatic run_hazard(input string name, input int a, input logic ea, input int b,
                            input logic eb, input logic m, input int want1, input int want2,
                            input int want4);
    logic [14:0] obs, exp;
    int st1 = 0, st2 = 0, st4 = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, a, ea, b, eb, 3, 1'b1, m, 1'b0);
      else        drive(1'b1, a, ea, b, eb, 3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      obs = {v4, v2, v1};
      exp = model_all();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b want=%b", name, k, obs, exp);
      end
      st1 += int'(v1[4]); st2 += int'(v2[4]); st4 += int'(v4[4]);
      advance();
    end
    n_cmp++;
    if (st1 != want1 || st2 != want2 || st4 != want4) begin
      n_fail++;
      $display("FAIL %s_len got=%0d/%0d/%0d want=%0d/%0d/%0d", name, st1, st2, st4,
               want1, want2, want4);
    end
  endtask

  task automatic test_load_use();
    run_hazard("lu_a", 3, 1'b1, 7, 1'b0, 1'b1, 1, 2, 4);
    run_hazard("lu_b", 9, 1'b0, 3, 1'b1, 1'b1, 1, 2, 4);
    run_hazard("lu_b_off", 9, 1'b0, 3, 1'b0, 1'b1, 0, 0, 0);
    run_hazard("no_load", 3, 1'b1, 3, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_branch_priority();
    logic [14:0] obs, exp;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(1'b1, 3, 1'b1, 0, 1'b0, 3, 1'b1, 1'b1, 1'b1);
      else        drive(1'b1, 3, 1'b1, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      obs = {v4, v2, v1};
      exp = model_all();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL branch cyc=%0d got=%b want=%b", k, obs, exp);
      end
      if (k == 0) begin
        n_cmp++;
        if (obs !== {3{5'b00110}}) begin
          n_fail++;
          $display("FAIL branch_prio got=%b want=%b", obs, {3{5'b00110}});
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [14:0] obs, exp;
    int st4 = 0;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0:       drive(1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        1:       drive(1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        3:       drive(1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        default: drive(1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      obs = {v4, v2, v1};
      exp = model_all();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rst_mid cyc=%0d got=%b want=%b", k, obs, exp);
      end
      if (k == 2) begin
        n_cmp++;
        if (v4 !== 5'b0) begin
          n_fail++;
          $display("FAIL rst_mid_abort got=%b want=%b", v4, 5'b0);
        end
      end
      if (k >= 3) st4 += int'(v4[4]);
      advance();
    end
    n_cmp++;
    if (st4 != 4) begin
      n_fail++;
      $display("FAIL rst_mid_len got=%0d want=%0d", st4, 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] obs, exp;
    for (int k = 0; k < 14; k++) begin
      if (k < 7) drive(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b0);
      else       drive(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      obs = {v4, v2, v1};
      exp = model_all();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", k, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [14:0] obs, exp;
    logic        busy_any;
    for (int k = 0; k < 400; k++) begin
      busy_any = (rem[0] > 0) || (rem[1] > 0) || (rem[2] > 0);
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            !busy_any && ($urandom_range(0, 7) == 0));
      @(negedge clk);
      obs = {v4, v2, v1};
      exp = model_all();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b want=%b", k, obs, exp);
      end
      advance();
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    advance();
    for (int h = 0; h < 5; h++) begin
      if (h < 3) drive(1'b1, 2, 1'b1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
      else       drive(1'b1, 2, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      advance();
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 2, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        advance();
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sc2 !== 16'd6 || fc2 !== 16'd2) begin
      n_fail++;
      $display("FAIL stats2 got=%0d/%0d want=6/2", sc2, fc2);
    end
    n_cmp++;
    if (sc1 !== 16'(sc[0]) || sc4 !== 16'(sc[2]) || fc1 !== 16'(fc[0]) || fc4 !== 16'(fc[2]))
    begin
      n_fail++;
      $display("FAIL stats14 got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", sc1, sc4, fc1, fc4,
               sc[0], sc[2], fc[0], fc[2]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      sc[i]  = 0;
      fc[i]  = 0;
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
